// File: rtl/keyed_stream_arb_mux.sv
// N-to-1 stream multiplexer with keyed or round-robin grant, burst locking
// and a one-entry registered output stage.
module keyed_stream_arb_mux #(
  parameter int NR_CH    = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 32,
  parameter int MODE     = 0,
  localparam int CH_W    = (NR_CH > 2) ? $clog2(NR_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [KEY_LEN-1:0]        sel_key,
  input  logic [NR_CH*KEY_LEN-1:0]  ch_key,
  input  logic [NR_CH-1:0]          in_valid,
  output logic [NR_CH-1:0]          in_ready,
  input  logic [NR_CH*DATA_LEN-1:0] in_data,
  input  logic [NR_CH-1:0]          in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_LEN-1:0]       out_data,
  output logic                      out_last,
  output logic [CH_W-1:0]           out_ch,
  output logic                      miss
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_reg, state_next;
  logic [CH_W-1:0]     lock_ch_reg, lock_ch_next;
  logic [CH_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic                out_valid_reg;
  logic [DATA_LEN-1:0] out_data_reg;
  logic                out_last_reg;
  logic [CH_W-1:0]     out_ch_reg;
  logic                miss_reg;

  logic [NR_CH-1:0]    key_hit;
  logic [DATA_LEN-1:0] ch_data [NR_CH];
  logic [CH_W:0]       key_pick, rr_pick_res;
  logic [CH_W-1:0]     grant;
  logic                grant_vld;
  logic                can_take;
  logic                xfer;
  logic                sel_last;

  generate
    for (genvar gi = 0; gi < NR_CH; gi++) begin : g_ch
      assign key_hit[gi]  = (ch_key[KEY_LEN*gi +: KEY_LEN] == sel_key);
      assign ch_data[gi]  = in_data[DATA_LEN*gi +: DATA_LEN];
      assign in_ready[gi] = grant_vld && (grant == CH_W'(gi)) && can_take;
    end
  endgenerate

  // Returns {found, index} of the first set bit at or after ptr, wrapping.
  function automatic logic [CH_W:0] first_from(input logic [NR_CH-1:0] v,
                                               input logic [CH_W-1:0]  ptr);
    logic [CH_W:0] res;
    int            idx;
    res = '0;
    for (int k = NR_CH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NR_CH) idx = idx - NR_CH;
      if (v[idx]) res = {1'b1, CH_W'(idx)};
    end
    return res;
  endfunction

  assign key_pick    = first_from(key_hit, '0);
  assign rr_pick_res = first_from(in_valid, rr_ptr_reg);

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    if (state_reg == LOCKED) begin
      grant     = lock_ch_reg;
      grant_vld = 1'b1;
    end else if (MODE == 1) begin
      grant     = rr_pick_res[CH_W-1:0];
      grant_vld = rr_pick_res[CH_W];
    end else begin
      grant     = key_pick[CH_W-1:0];
      grant_vld = key_pick[CH_W];
    end
  end

  assign can_take = !out_valid_reg || out_ready;
  assign xfer     = grant_vld && can_take && in_valid[grant];
  assign sel_last = in_last[grant];

  always_comb begin
    state_next   = state_reg;
    lock_ch_next = lock_ch_reg;
    rr_ptr_next  = rr_ptr_reg;
    if (xfer) begin
      if (sel_last) begin
        state_next  = IDLE;
        rr_ptr_next = (grant == CH_W'(NR_CH - 1)) ? '0 : grant + 1'b1;
      end else begin
        state_next   = LOCKED;
        lock_ch_next = grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      lock_ch_reg   <= '0;
      rr_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_ch_reg    <= '0;
      miss_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lock_ch_reg <= lock_ch_next;
      rr_ptr_reg  <= rr_ptr_next;
      // A load in the same cycle as a drain keeps out_valid high.
      if (xfer) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= ch_data[grant];
        out_last_reg  <= sel_last;
        out_ch_reg    <= grant;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      miss_reg <= (state_reg == IDLE) && (MODE == 0) && !key_pick[CH_W];
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign out_ch    = out_ch_reg;
  assign miss      = miss_reg;

endmodule
